// File: rtl/bram_arb_if.sv
// Round-robin arbiter that multiplexes up to eight requesters onto one BRAM port,
// with configurable read latency, byte enables and optional write read-back verify.
module bram_arb_if #(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 32,
   parameter int RD_LAT    = 1,
   parameter int WR_VERIFY = 0
) (
   input  logic                       axi_clk,
   input  logic                       axi_rst,
   input  logic [NUM_CH-1:0]          req_valid,
   input  logic [NUM_CH-1:0]          req_we,
   input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
   input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
   input  logic [NUM_CH*DATA_W/8-1:0] req_be,
   output logic [NUM_CH-1:0]          rsp_done,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_verr,
   output logic                       busy,
   output logic [ADDR_W-1:0]          addr_BRAM,
   output logic                       clk_BRAM,
   output logic [DATA_W-1:0]          dout_BRAM,
   input  logic [DATA_W-1:0]          din_BRAM,
   output logic                       en_BRAM,
   output logic                       rst_BRAM,
   output logic [DATA_W/8-1:0]        we_BRAM
);

   localparam int BE_W = DATA_W / 8;
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_VRD   = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]        state_r;
   logic [CH_W-1:0]   last_gnt_r;
   logic [CH_W-1:0]   gnt_r;
   logic              cap_we_r;
   logic [BE_W-1:0]   cap_be_r;
   logic [1:0]        cnt_r;
   logic [NUM_CH-1:0] done_r;
   logic [DATA_W-1:0] rdata_r;
   logic              verr_r;
   logic              busy_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] dout_r;
   logic              en_r;
   logic [BE_W-1:0]   we_r;

   logic              gnt_any_s;
   logic [CH_W-1:0]   gnt_idx_s;
   logic [NUM_CH-1:0] done_vec_s;

   function automatic logic verify_mismatch(input logic [DATA_W-1:0] rd,
                                            input logic [DATA_W-1:0] wd,
                                            input logic [BE_W-1:0]   be);
      logic m;
      m = 1'b0;
      for (int b = 0; b < BE_W; b++) begin
         m = m | (be[b] & (rd[b*8 +: 8] != wd[b*8 +: 8]));
      end
      return m;
   endfunction

   assign gnt_any_s = |req_valid;

   // Round-robin pick: scan downward so the first requester after last_gnt wins.
   always_comb begin
      gnt_idx_s = last_gnt_r;
      for (int k = NUM_CH; k >= 1; k--) begin
         gnt_idx_s = req_valid[(int'(last_gnt_r) + k) % NUM_CH] ?
                     CH_W'((int'(last_gnt_r) + k) % NUM_CH) : gnt_idx_s;
      end
   end

   // One-hot completion vector for the channel holding the grant.
   always_comb begin
      done_vec_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         done_vec_s[i] = (gnt_r == CH_W'(i));
      end
   end

   // Transaction sequencer; BRAM strobes are registered on entry to each state.
   always_ff @(posedge axi_clk or negedge axi_rst) begin
      if (!axi_rst) begin
         state_r    <= ST_IDLE;
         last_gnt_r <= CH_W'(NUM_CH - 1);
         gnt_r      <= {CH_W{1'b0}};
         cap_we_r   <= 1'b0;
         cap_be_r   <= {BE_W{1'b0}};
         cnt_r      <= 2'd0;
         done_r     <= {NUM_CH{1'b0}};
         rdata_r    <= {DATA_W{1'b0}};
         verr_r     <= 1'b0;
         busy_r     <= 1'b0;
         addr_r     <= {ADDR_W{1'b0}};
         dout_r     <= {DATA_W{1'b0}};
         en_r       <= 1'b0;
         we_r       <= {BE_W{1'b0}};
      end else begin
         done_r <= {NUM_CH{1'b0}};
         verr_r <= 1'b0;
         en_r   <= 1'b0;
         we_r   <= {BE_W{1'b0}};
         case (state_r)
            ST_IDLE: begin
               if (gnt_any_s) begin
                  state_r    <= ST_ISSUE;
                  busy_r     <= 1'b1;
                  last_gnt_r <= gnt_idx_s;
                  gnt_r      <= gnt_idx_s;
                  cap_we_r   <= req_we[gnt_idx_s];
                  cap_be_r   <= req_be[gnt_idx_s*BE_W +: BE_W];
                  addr_r     <= req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
                  dout_r     <= req_wdata[gnt_idx_s*DATA_W +: DATA_W];
                  en_r       <= 1'b1;
                  we_r       <= req_we[gnt_idx_s] ? req_be[gnt_idx_s*BE_W +: BE_W]
                                                  : {BE_W{1'b0}};
               end
            end
            ST_ISSUE: begin
               if (cap_we_r && (WR_VERIFY != 0)) begin
                  state_r <= ST_VRD;
                  en_r    <= 1'b1;
               end else if (cap_we_r) begin
                  state_r <= ST_DONE;
                  done_r  <= done_vec_s;
               end else begin
                  state_r <= ST_WAIT;
                  cnt_r   <= 2'(RD_LAT - 1);
               end
            end
            ST_VRD: begin
               state_r <= ST_WAIT;
               cnt_r   <= 2'(RD_LAT - 1);
            end
            ST_WAIT: begin
               if (cnt_r == 2'd0) begin
                  state_r <= ST_DONE;
                  done_r  <= done_vec_s;
                  rdata_r <= din_BRAM;
                  verr_r  <= cap_we_r & (WR_VERIFY != 0) &
                             verify_mismatch(din_BRAM, dout_r, cap_be_r);
               end else begin
                  cnt_r <= cnt_r - 2'd1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_done  = done_r;
   assign rsp_rdata = rdata_r;
   assign rsp_verr  = verr_r;
   assign busy      = busy_r;
   assign addr_BRAM = addr_r;
   assign dout_BRAM = dout_r;
   assign en_BRAM   = en_r;
   assign we_BRAM   = we_r;
   assign clk_BRAM  = axi_clk;
   assign rst_BRAM  = ~axi_rst;

endmodule

// File: tb/tb_bram_arb_if.sv
// Directed bench: two instances (RD_LAT=1/no verify, RD_LAT=3/verify) share stimulus,
// each with its own behavioural BRAM; sel chooses which one the checks observe.
module tb_bram_arb_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_init;
   logic        sel;
   logic [1:0]  req_valid;
   logic [1:0]  req_we;
   logic [63:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic [15:0] corrupt_b;

   logic [1:0]  done_a, done_b, we_a, we_b;
   logic [15:0] rdata_a, rdata_b, dout_a, dout_b, din_a, din_b;
   logic        verr_a, verr_b, busy_a, busy_b, en_a, en_b;
   logic        clkb_a, clkb_b, rstb_a, rstb_b;
   logic [31:0] addr_a, addr_b;

   logic [15:0] mem_a [0:255];
   logic [15:0] mem_b [0:255];
   logic [15:0] p1, p2, p3;

   logic [1:0]  o_done, o_we;
   logic [15:0] o_rdata, o_dout;
   logic        o_verr, o_busy, o_en;
   logic [31:0] o_addr;

   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;
   int          cyc;
   int          t_cyc, t_en;
   logic [1:0]  t_done, t_iss_we;
   logic [15:0] t_rdata, t_iss_dout;
   logic        t_verr, t_addr_ok;

   always #5 clk = ~clk;

   bram_arb_if #(.NUM_CH(2), .DATA_W(16), .ADDR_W(32), .RD_LAT(1), .WR_VERIFY(0)) u_a (
      .axi_clk(clk), .axi_rst(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_done(done_a), .rsp_rdata(rdata_a), .rsp_verr(verr_a), .busy(busy_a),
      .addr_BRAM(addr_a), .clk_BRAM(clkb_a), .dout_BRAM(dout_a), .din_BRAM(din_a),
      .en_BRAM(en_a), .rst_BRAM(rstb_a), .we_BRAM(we_a));

   bram_arb_if #(.NUM_CH(2), .DATA_W(16), .ADDR_W(32), .RD_LAT(3), .WR_VERIFY(1)) u_b (
      .axi_clk(clk), .axi_rst(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_done(done_b), .rsp_rdata(rdata_b), .rsp_verr(verr_b), .busy(busy_b),
      .addr_BRAM(addr_b), .clk_BRAM(clkb_b), .dout_BRAM(dout_b), .din_BRAM(din_b),
      .en_BRAM(en_b), .rst_BRAM(rstb_b), .we_BRAM(we_b));

   assign o_done  = sel ? done_b  : done_a;
   assign o_rdata = sel ? rdata_b : rdata_a;
   assign o_verr  = sel ? verr_b  : verr_a;
   assign o_busy  = sel ? busy_b  : busy_a;
   assign o_en    = sel ? en_b    : en_a;
   assign o_we    = sel ? we_b    : we_a;
   assign o_addr  = sel ? addr_b  : addr_a;
   assign o_dout  = sel ? dout_b  : dout_a;

   // Latency-1 BRAM for instance A
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= 16'h0000;
         mem_a[8'h20] <= 16'h1111;
         mem_a[8'h21] <= 16'h2222;
      end else if (en_a) begin
         if (we_a[0]) mem_a[addr_a[7:0]][7:0]  <= dout_a[7:0];
         if (we_a[1]) mem_a[addr_a[7:0]][15:8] <= dout_a[15:8];
         din_a <= mem_a[addr_a[7:0]];
      end
   end

   // Latency-3 BRAM for instance B, with a fault-injection mask on its output
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= 16'h0000;
         mem_b[8'h40] <= 16'hAAAA;
         mem_b[8'h21] <= 16'h5555;
      end else if (en_b) begin
         if (we_b[0]) mem_b[addr_b[7:0]][7:0]  <= dout_b[7:0];
         if (we_b[1]) mem_b[addr_b[7:0]][15:8] <= dout_b[15:8];
         p1 <= mem_b[addr_b[7:0]];
      end
      p2 <= p1;
      p3 <= p2;
   end
   assign din_b = p3 ^ corrupt_b;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input int ch, input logic we, input logic [31:0] addr,
                          input logic [15:0] wd, input logic [1:0] be);
      req_we[ch] = we;
      req_addr[ch*32 +: 32] = addr;
      req_wdata[ch*16 +: 16] = wd;
      req_be[ch*2 +: 2] = be;
      req_valid = 2'b00;
      req_valid[ch] = 1'b1;
      t_cyc = 0; t_en = 0; t_addr_ok = 1'b1; t_iss_we = 2'b00; t_iss_dout = 16'h0000;
      do begin
         @(negedge clk);
         t_cyc++;
         if (o_en) t_en++;
         if (o_addr !== addr) t_addr_ok = 1'b0;
         if (t_cyc == 1) begin
            t_iss_we = o_we;
            t_iss_dout = o_dout;
            req_addr[ch*32 +: 32] = addr ^ 32'h0000_0003;
         end
      end while (o_done == 2'b00 && t_cyc < 30);
      t_done = o_done; t_rdata = o_rdata; t_verr = o_verr;
      req_valid = 2'b00;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      sel = 1'b0; rst_n = 1'b0; mem_init = 1'b1; corrupt_b = 16'h0000;
      req_valid = 2'b11; req_we = 2'b00; req_addr = {32'h21, 32'h20};
      req_wdata = 32'h0; req_be = 4'hF;
      repeat (2) @(negedge clk);
      mem_init = 1'b0;
      @(negedge clk);
      chk("rst_outs_a", {done_a, rdata_a, verr_a, busy_a, en_a, we_a, dout_a}, 64'h0);
      chk("rst_outs_b", {done_b, rdata_b, verr_b, busy_b, en_b, we_b, dout_b}, 64'h0);
      chk("rst_addr", {addr_a, addr_b}, 64'h0);
      chk("rst_BRAM", {rstb_a, rstb_b}, 2'b11);
      chk("clk_BRAM", {clkb_a, clkb_b}, {clk, clk});
      rst_n = 1'b1;

      // both channels read continuously: grants alternate starting with ch0
      for (int i = 0; i < 4; i++) begin
         cyc = 0;
         do begin @(negedge clk); cyc++; end while (o_done == 2'b00 && cyc < 20);
         chk($sformatf("rr_lat%0d", i), cyc, (i == 0) ? 3 : 4);
         chk($sformatf("rr_gnt%0d", i), o_done, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("rr_rdata%0d", i), o_rdata, (i % 2 == 0) ? 16'h1111 : 16'h2222);
      end
      req_valid = 2'b00;
      repeat (12) @(negedge clk);
      chk("idle_busy", {busy_a, busy_b}, 2'b00);
      chk("rst_BRAM_rel", {rstb_a, rstb_b}, 2'b00);

      run_txn(0, 1'b1, 32'h10, 16'hBEEF, 2'b11);
      chk("wr_lat", t_cyc, 2);
      chk("wr_done", t_done, 2'b01);
      chk("wr_iss_we", t_iss_we, 2'b11);
      chk("wr_iss_dout", t_iss_dout, 16'hBEEF);
      chk("wr_hold_rdata", t_rdata, 16'h2222);
      chk("wr_en_cyc", t_en, 1);
      chk("wr_addr", t_addr_ok, 1'b1);

      run_txn(0, 1'b0, 32'h10, 16'h0000, 2'b11);
      chk("rd_lat", t_cyc, 3);
      chk("rd_done", t_done, 2'b01);
      chk("rd_rdata", t_rdata, 16'hBEEF);
      chk("rd_iss_we", t_iss_we, 2'b00);

      run_txn(0, 1'b1, 32'h10, 16'h0000, 2'b00);
      chk("be0_lat", t_cyc, 2);
      chk("be0_done", t_done, 2'b01);
      chk("be0_en", t_en, 1);
      run_txn(0, 1'b0, 32'h10, 16'h0000, 2'b00);
      chk("be0_rdata", t_rdata, 16'hBEEF);

      run_txn(1, 1'b1, 32'h10, 16'h1234, 2'b10);
      chk("be_hi_done", t_done, 2'b10);
      chk("be_hi_iss_we", t_iss_we, 2'b10);
      run_txn(1, 1'b0, 32'h10, 16'h0000, 2'b11);
      chk("be_hi_rdata", t_rdata, 16'h12EF);
      chk("be_hi_done2", t_done, 2'b10);

      sel = 1'b1;
      run_txn(0, 1'b1, 32'h40, 16'h1234, 2'b01);
      chk("vfy_lat", t_cyc, 6);
      chk("vfy_done", t_done, 2'b01);
      chk("vfy_rdata", t_rdata, 16'hAA34);
      chk("vfy_verr", t_verr, 1'b0);
      chk("vfy_en_cyc", t_en, 2);
      chk("vfy_iss_we", t_iss_we, 2'b01);

      corrupt_b = 16'h0001;
      run_txn(0, 1'b1, 32'h40, 16'h5678, 2'b01);
      chk("vfy_bad_verr", t_verr, 1'b1);
      chk("vfy_bad_rdata", t_rdata, 16'hAA79);

      corrupt_b = 16'h0100;
      run_txn(0, 1'b1, 32'h40, 16'h9999, 2'b01);
      chk("vfy_mask_verr", t_verr, 1'b0);
      chk("vfy_mask_rdata", t_rdata, 16'hAB99);
      corrupt_b = 16'h0000;

      run_txn(0, 1'b0, 32'h40, 16'h0000, 2'b00);
      chk("rd3_lat", t_cyc, 5);
      chk("rd3_en_cyc", t_en, 1);
      chk("rd3_addr_hold", t_addr_ok, 1'b1);
      chk("rd3_rdata", t_rdata, 16'hAA99);
      chk("rd3_verr", t_verr, 1'b0);

      // asynchronous reset while B sits in WAIT
      req_we = 2'b00; req_addr = {32'h21, 32'h40}; req_valid = 2'b01;
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", o_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_en_we", {o_en, o_we}, 3'b000);
      chk("arst_busy", o_busy, 1'b0);
      req_valid = 2'b11;
      @(negedge clk);
      chk("arst_no_done", {o_done, o_rdata}, 18'h0);
      rst_n = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (o_done == 2'b00 && cyc < 20);
      chk("post_rst_lat", cyc, 5);
      chk("post_rst_gnt", o_done, 2'b01);
      chk("post_rst_rdata", o_rdata, 16'hAA99);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (o_done == 2'b00 && cyc < 20);
      chk("post_rst_lat2", cyc, 6);
      chk("post_rst_gnt2", o_done, 2'b10);
      chk("post_rst_rdata2", o_rdata, 16'h5555);
      req_valid = 2'b00;
      repeat (10) @(negedge clk);

      if (n_pass + n_fail != n_total) $display("check count inconsistent");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bram_arb_if.md
# bram_arb_if

Multi-channel, parametrised BRAM interface that arbitrates read and write requests from up to eight requesters (AXI slave, NN engines, DMA) onto a single BRAM port. It is the next generation of the single-port BRAM interface state machine and adds four things: generic data/address width, configurable BRAM read latency, per-byte write enables and optional write-verify read-back. It sits between the requesters and the Xilinx BRAM primitive and runs entirely on the rising edge of one clock.

## Interface
- NUM_CH, 2: number of requester channels, 1..8
- DATA_W, 16: BRAM data width in bits; must be a multiple of 8
- ADDR_W, 32: BRAM address width
- RD_LAT, 1: BRAM read latency in cycles (en sampled to dout valid), 1..4
- WR_VERIFY, 0: 1 = every write is followed by a read-back of the same address
- axi_clk  in  1  clock; all logic on the rising edge. One clock only.
- axi_rst  in  1  reset; asynchronous assert, active-low
- req_valid  in  NUM_CH  per-channel request
- req_we  in  NUM_CH  per-channel: 1 = write, 0 = read
- req_addr  in  NUM_CH*ADDR_W  per-channel address; channel i in bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  per-channel write data
- req_be  in  NUM_CH*DATA_W/8  per-channel byte enables
- rsp_done  out  NUM_CH  one-hot, one-cycle completion pulse to the granted channel
- rsp_rdata  out  DATA_W  read or read-back data; valid when any rsp_done bit is set
- rsp_verr  out  1  write-verify mismatch; valid with rsp_done; always 0 when WR_VERIFY=0
- busy  out  1  FSM is not in IDLE
- addr_BRAM  out  ADDR_W  BRAM address
- clk_BRAM  out  1  equals axi_clk
- dout_BRAM  out  DATA_W  to BRAM DIN
- din_BRAM  in  DATA_W  from BRAM DOUT
- en_BRAM  out  1  BRAM enable
- rst_BRAM  out  1  equals ~axi_rst (combinational)
- we_BRAM  out  DATA_W/8  byte write enables

## Operation
- Reset (axi_rst=0): all registered outputs are 0, the FSM is in IDLE and the round-robin pointer last_gnt = NUM_CH-1, so channel 0 wins the first arbitration.
- FSM states:
  - IDLE -> ISSUE when any req_valid bit is set.
  - ISSUE -> WAIT on a read or a verify read-back; ISSUE -> DONE on a write when WR_VERIFY=0; ISSUE -> VRD on a write when WR_VERIFY=1.
  - VRD -> WAIT.
  - WAIT counts RD_LAT cycles, then -> DONE.
  - DONE -> IDLE.
- Arbitration happens only in IDLE and is round-robin: the grant goes to the first requesting channel after last_gnt in ascending index, wrapping. last_gnt is updated at grant. When only one channel requests, it wins every time.
- At grant, the channel's we, addr, wdata and be are captured. Later changes to that channel's req_* inputs are ignored until its rsp_done.
- ISSUE:
  - en_BRAM=1 and addr_BRAM=captured address.
  - Write: we_BRAM=captured be, dout_BRAM=wdata.
  - Read: we_BRAM=0.
- VRD: en_BRAM=1, we_BRAM=0, same address (read-back).
- WAIT: en_BRAM=0, we_BRAM=0. At the end of the final WAIT cycle, din_BRAM is registered into rsp_rdata.
- DONE:
  - rsp_done[granted] pulses for one cycle.
  - rsp_verr = 1 if any byte with be=1 differs between rsp_rdata and wdata.
  - After a write with WR_VERIFY=0, rsp_rdata holds its previous value.
- Handshake: a requester holds req_valid and its fields stable until it sees rsp_done. If req_valid is still 1 in the cycle after rsp_done, that is a new request.
- A channel that drops req_valid before grant produces no transaction. One that drops it after grant still completes and still receives rsp_done.
- be=0 on a write still performs the BRAM cycle (no bytes change) and completes normally.
- Async reset mid-transaction: en_BRAM and we_BRAM go to 0 immediately, the transaction is discarded and no rsp_done is issued.

## Timing
- Cycle 0 is the IDLE cycle in which req_valid is sampled.
- Read: ISSUE in cycle 1; rsp_done and rsp_rdata in cycle 2+RD_LAT.
- Write, WR_VERIFY=0: ISSUE in cycle 1; rsp_done in cycle 2.
- Write, WR_VERIFY=1: write in cycle 1, read-back in cycle 2; rsp_done and rsp_verr in cycle 3+RD_LAT.
- The FSM is in IDLE the cycle after DONE, so a back-to-back read costs RD_LAT+3 cycles per transaction.
- busy is high from ISSUE through DONE inclusive.

## Test plan
- Reset with all req_valid held high -> while axi_rst=0, all outputs 0 and rst_BRAM=1. After release, channel 0 is granted first.
- NUM_CH=2, RD_LAT=1, ch0 writes 0xBEEF to address 0x10 (be=2'b11), then ch0 reads 0x10 -> write rsp_done in cycle 2; read rsp_done in cycle 3 with rsp_rdata=0xBEEF.
- Both channels hold continuous reads -> grants alternate ch0, ch1, ch0, ch1; the rsp_done one-hot matches each grant; neither channel is starved.
- WR_VERIFY=1, write 0x1234 with be=2'b01 over existing 0xAAAA -> rsp_rdata=0xAA34, rsp_verr=0. Force a corrupted din_BRAM byte -> rsp_verr=1.
- RD_LAT=3 read -> en_BRAM high only in cycle 1; rsp_done in cycle 5; changing req_addr after grant has no effect on addr_BRAM.
- Assert axi_rst low during WAIT -> en_BRAM/we_BRAM go to 0 asynchronously, no rsp_done. After release, the same request is re-granted to channel 0.
